// File: rtl/fab_apb_arb_pkg.sv
// Shared definitions for the fabric APB arbiter slice.
//   state_t            : arbiter FSM encoding (IDLE/SETUP/ACCESS/DONE)
//   REQ_IDX_0/1        : requester index values used for grants
//   TIMEOUT_CYCLES_DEF : default ACCESS-phase PREADY timeout
package fab_apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic REQ_IDX_0 = 1'b0;
    localparam logic REQ_IDX_1 = 1'b1;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

endpackage

// File: rtl/fab_apb_arbiter_if.sv
// Bus bundle for fab_apb_arbiter: two request/acknowledge requester ports
// plus the fabric-to-MSS APB3 (FABP*) master port.
//   master : arbiter view (drives ACKn/RDATAn/ERRn and FABP* requests)
//   slave  : environment view (requesters and the MSS APB slave)
interface fab_apb_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              REQ0,   REQ1;
    logic              WRITE0, WRITE1;
    logic [ADDR_W-1:0] ADDR0,  ADDR1;
    logic [DATA_W-1:0] WDATA0, WDATA1;
    logic              ACK0,   ACK1;
    logic [DATA_W-1:0] RDATA0, RDATA1;
    logic              ERR0,   ERR1;

    logic [ADDR_W-1:0] FABPADDR;
    logic [DATA_W-1:0] FABPWDATA;
    logic              FABPWRITE;
    logic              FABPSEL;
    logic              FABPENABLE;
    logic [DATA_W-1:0] FABPRDATA;
    logic              FABPREADY;
    logic              FABPSLVERR;

    modport master (
        input  REQ0, REQ1, WRITE0, WRITE1, ADDR0, ADDR1, WDATA0, WDATA1,
        output ACK0, ACK1, RDATA0, RDATA1, ERR0, ERR1,
        output FABPADDR, FABPWDATA, FABPWRITE, FABPSEL, FABPENABLE,
        input  FABPRDATA, FABPREADY, FABPSLVERR
    );

    modport slave (
        output REQ0, REQ1, WRITE0, WRITE1, ADDR0, ADDR1, WDATA0, WDATA1,
        input  ACK0, ACK1, RDATA0, RDATA1, ERR0, ERR1,
        input  FABPADDR, FABPWDATA, FABPWRITE, FABPSEL, FABPENABLE,
        output FABPRDATA, FABPREADY, FABPSLVERR
    );

endinterface

// File: rtl/fab_rr_arb2.sv
// Combinational two-way round-robin pick.
//   req[1:0]   : pending requests (bit n = requester n)
//   last_grant : index granted most recently
//   grant_idx  : chosen requester (valid only when grant_vld=1)
//   grant_vld  : at least one request pending
module fab_rr_arb2
    import fab_apb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_idx,
    output logic       grant_vld
);

    always_comb begin
        grant_vld = |req;
        grant_idx = REQ_IDX_0;
        case (req)
            2'b01:   grant_idx = REQ_IDX_0;
            2'b10:   grant_idx = REQ_IDX_1;
            // contention: the requester that did not win last time goes first
            2'b11:   grant_idx = (last_grant == REQ_IDX_0) ? REQ_IDX_1 : REQ_IDX_0;
            default: grant_idx = REQ_IDX_0;
        endcase
    end

endmodule

// File: rtl/fab_apb_arbiter.sv
// Shares the MSS FABP* APB3 slave port between two fabric requesters.
// Round-robin grant, APB SETUP/ACCESS sequencing, read-data/error capture
// and a PREADY timeout.
//   FAB_CLK    : fabric clock, rising edge
//   M2FRESETn  : asynchronous active-low reset
//   bus        : requester ports and FABP* master port (master modport)
module fab_apb_arbiter
    import fab_apb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32
) (
    input  logic               FAB_CLK,
    input  logic               M2FRESETn,
    fab_apb_arbiter_if.master  bus
);

    localparam logic [15:0] CNT_TERM = 16'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic              grant_q, last_grant_q;
    logic [15:0]       cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic arb_idx, arb_vld;
    logic misaligned, timeout, ack0, ack1;

    fab_rr_arb2 u_rr_arb2 (
        .req        ({bus.REQ1, bus.REQ0}),
        .last_grant (last_grant_q),
        .grant_idx  (arb_idx),
        .grant_vld  (arb_vld)
    );

    assign misaligned = (addr_q[1:0] != 2'b00);
    assign timeout    = (cnt_q == CNT_TERM);

    always_ff @(posedge FAB_CLK or negedge M2FRESETn) begin
        if (!M2FRESETn) state <= IDLE;
        else            state <= state_nxt;
    end

    // The alignment check runs on the latched address, so a misaligned
    // request spends its SETUP cycle with FABPSEL held low and then completes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_vld) state_nxt = SETUP;
            SETUP:   state_nxt = misaligned ? DONE : ACCESS;
            ACCESS:  if (bus.FABPREADY || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK or negedge M2FRESETn) begin
        if (!M2FRESETn) begin
            grant_q      <= REQ_IDX_0;
            last_grant_q <= REQ_IDX_1;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_vld) begin
                        grant_q <= arb_idx;
                        addr_q  <= (arb_idx == REQ_IDX_1) ? bus.ADDR1  : bus.ADDR0;
                        wdata_q <= (arb_idx == REQ_IDX_1) ? bus.WDATA1 : bus.WDATA0;
                        write_q <= (arb_idx == REQ_IDX_1) ? bus.WRITE1 : bus.WRITE0;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                SETUP: begin
                    if (misaligned) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + 16'd1;
                    // PREADY on the terminal count still wins
                    if (bus.FABPREADY) begin
                        rdata_q <= write_q ? '0 : bus.FABPRDATA;
                        err_q   <= bus.FABPSLVERR;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                DONE: begin
                    last_grant_q <= grant_q;
                    cnt_q        <= '0;
                end
                default: ;
            endcase
        end
    end

    // Bus strobes and acknowledges decode straight from the state register,
    // so an asynchronous reset drops them immediately.
    assign ack0 = (state == DONE) && (grant_q == REQ_IDX_0);
    assign ack1 = (state == DONE) && (grant_q == REQ_IDX_1);

    assign bus.FABPSEL    = ((state == SETUP) && !misaligned) || (state == ACCESS);
    assign bus.FABPENABLE = (state == ACCESS);
    assign bus.FABPADDR   = addr_q;
    assign bus.FABPWDATA  = wdata_q;
    assign bus.FABPWRITE  = write_q;

    assign bus.ACK0   = ack0;
    assign bus.ACK1   = ack1;
    assign bus.RDATA0 = ack0 ? rdata_q : '0;
    assign bus.RDATA1 = ack1 ? rdata_q : '0;
    assign bus.ERR0   = ack0 & err_q;
    assign bus.ERR1   = ack1 & err_q;

endmodule

// File: tb/tb_fab_apb_arbiter.sv
module tb_fab_apb_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fab_apb_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    fab_apb_arbiter #(
        .TIMEOUT_CYCLES (8),
        .ADDR_W         (32),
        .DATA_W         (32)
    ) dut (
        .FAB_CLK   (clk),
        .M2FRESETn (rst_n),
        .bus       (bus)
    );

    // MSS APB slave model: PREADY after 'waits_v' ACCESS wait cycles
    int          waits_v  = 0;
    logic [31:0] prdata_v = '0;
    logic        slverr_v = 1'b0;
    int          acc_cnt  = 0;

    always @(posedge clk)
        acc_cnt <= (bus.FABPSEL && bus.FABPENABLE && !bus.FABPREADY) ? acc_cnt + 1 : 0;

    assign bus.FABPREADY  = bus.FABPSEL && bus.FABPENABLE && (acc_cnt == waits_v);
    assign bus.FABPRDATA  = prdata_v;
    assign bus.FABPSLVERR = slverr_v;

    typedef struct {
        logic        idx;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        idx;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          start;
        int          lat;
    } sb_t;

    sb_t sb[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        else             n_pass++;
    endtask

    // Scoreboard monitor: compares every ACK and every APB cycle to the queue
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_ack)
                check("ack_pulse_clear",
                      {27'd0, bus.ACK0, bus.ACK1, bus.ERR0, bus.ERR1,
                       (bus.RDATA0 != 0 || bus.RDATA1 != 0)}, 32'd0);
            if (sb.size() > 0) begin
                if (sb[0].addr[1:0] != 2'b00)
                    check("no_psel_misaligned", 32'(bus.FABPSEL), 32'd0);
                else if (bus.FABPSEL) begin
                    check("paddr",  bus.FABPADDR,         sb[0].addr);
                    check("pwdata", bus.FABPWDATA,        sb[0].wdata);
                    check("pwrite", 32'(bus.FABPWRITE),   32'(sb[0].write));
                end
            end
            if (bus.ACK0 || bus.ACK1) begin
                check("ack_exclusive", 32'(bus.ACK0 & bus.ACK1), 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("grant_idx", 32'(bus.ACK1), 32'(e.idx));
                    check("latency",   32'(cyc - e.start), 32'(e.lat));
                    if (bus.ACK1) begin
                        check("rdata1", bus.RDATA1, e.exp_rdata);
                        check("err1",   32'(bus.ERR1), 32'(e.exp_err));
                        check("idle_side0", {30'd0, bus.ERR0, (bus.RDATA0 != 0)}, 32'd0);
                    end else begin
                        check("rdata0", bus.RDATA0, e.exp_rdata);
                        check("err0",   32'(bus.ERR0), 32'(e.exp_err));
                        check("idle_side1", {30'd0, bus.ERR1, (bus.RDATA1 != 0)}, 32'd0);
                    end
                end
            end
            prev_ack <= bus.ACK0 | bus.ACK1;
        end else begin
            prev_ack <= 1'b0;
        end
    end

    task automatic wait_acks(input int n, input int limit);
        int got;
        got = 0;
        for (int i = 0; i < limit && got < n; i++) begin
            @(negedge clk);
            if (bus.ACK0 || bus.ACK1) got++;
        end
        check("ack_count", 32'(got), 32'(n));
        if (got < n) sb.delete();
    endtask

    task automatic drop_reqs();
        bus.REQ0 = 1'b0;
        bus.REQ1 = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        sb_t e;
        @(posedge clk); #1;
        waits_v  = v.waits;
        prdata_v = v.prdata;
        slverr_v = v.slverr;
        if (v.idx) begin
            bus.WRITE1 = v.write; bus.ADDR1 = v.addr; bus.WDATA1 = v.wdata; bus.REQ1 = 1'b1;
        end else begin
            bus.WRITE0 = v.write; bus.ADDR0 = v.addr; bus.WDATA0 = v.wdata; bus.REQ0 = 1'b1;
        end
        e = '{idx: v.idx, write: v.write, addr: v.addr, wdata: v.wdata,
              exp_rdata: v.exp_rdata, exp_err: v.exp_err, start: cyc, lat: v.exp_lat};
        sb.push_back(e);
        wait_acks(1, 40);
        @(posedge clk); #1;
        drop_reqs();
    endtask

    vec_t vecs[9];

    initial begin
        int k;
        int acks;
        // idx write addr wdata waits prdata slverr | exp_rdata exp_err exp_lat
        vecs[0] = '{1'b0, 1'b0, 32'h4000_0000, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[1] = '{1'b1, 1'b1, 32'h4000_0010, 32'h1234_5678, 3, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 6};
        vecs[2] = '{1'b0, 1'b0, 32'h4000_0004, 32'h0, 0, 32'h1111_2222, 1'b1, 32'h1111_2222, 1'b1, 3};
        vecs[3] = '{1'b0, 1'b0, 32'h4000_0002, 32'h0, 0, 32'h5555_5555, 1'b0, 32'h0, 1'b1, 2};
        vecs[4] = '{1'b1, 1'b0, 32'h4000_0008, 32'h0, 7, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 10};
        vecs[5] = '{1'b1, 1'b0, 32'h4000_000C, 32'h0, 255, 32'h7777_7777, 1'b0, 32'h0, 1'b1, 10};
        vecs[6] = '{1'b0, 1'b1, 32'h4000_0001, 32'h0BAD_0001, 0, 32'h0, 1'b0, 32'h0, 1'b1, 2};
        vecs[7] = '{1'b1, 1'b0, 32'h4000_0100, 32'h0, 1, 32'h0BAD_C0DE, 1'b0, 32'h0BAD_C0DE, 1'b0, 4};
        vecs[8] = '{1'b0, 1'b1, 32'h4000_0200, 32'hFEED_0001, 2, 32'hAAAA_AAAA, 1'b1, 32'h0, 1'b1, 5};

        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        bus.WRITE0 = 1'b0; bus.WRITE1 = 1'b0;
        bus.ADDR0 = '0; bus.ADDR1 = '0;
        bus.WDATA0 = '0; bus.WDATA1 = '0;

        // reset state
        #1;
        check("rst_psel_pen", {30'd0, bus.FABPSEL, bus.FABPENABLE}, 32'd0);
        check("rst_paddr",    bus.FABPADDR,  32'd0);
        check("rst_pwdata",   bus.FABPWDATA, 32'd0);
        check("rst_acks",     {28'd0, bus.ACK0, bus.ACK1, bus.ERR0, bus.ERR1}, 32'd0);
        check("rst_rdata",    bus.RDATA0 | bus.RDATA1, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // continuous dual requests from reset: 0,1,0,1
        @(posedge clk); #1;
        waits_v = 0; prdata_v = 32'h0000_1234; slverr_v = 1'b0;
        bus.WRITE0 = 1'b0; bus.ADDR0 = 32'h4000_0020; bus.WDATA0 = 32'h0;
        bus.WRITE1 = 1'b1; bus.ADDR1 = 32'h4000_0030; bus.WDATA1 = 32'hA5A5_5A5A;
        bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
        k = cyc;
        for (int i = 0; i < 4; i++) begin
            sb_t e;
            e.idx       = (i % 2 == 1);
            e.write     = e.idx;
            e.addr      = e.idx ? 32'h4000_0030 : 32'h4000_0020;
            e.wdata     = e.idx ? 32'hA5A5_5A5A : 32'h0;
            e.exp_rdata = e.idx ? 32'h0 : 32'h0000_1234;
            e.exp_err   = 1'b0;
            e.start     = k + 4 * i;
            e.lat       = 3;
            sb.push_back(e);
        end
        wait_acks(4, 60);
        @(posedge clk); #1;
        drop_reqs();

        // table-driven single transactions
        for (int i = 0; i < 9; i++) do_txn(vecs[i]);

        // reset during ACCESS abandons the transfer
        @(posedge clk); #1;
        waits_v = 255; prdata_v = 32'h0;
        bus.WRITE0 = 1'b0; bus.ADDR0 = 32'h4000_0040; bus.REQ0 = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("access_psel_pen", {30'd0, bus.FABPSEL, bus.FABPENABLE}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_drop_psel_pen", {30'd0, bus.FABPSEL, bus.FABPENABLE}, 32'd0);
        check("async_clear_paddr", bus.FABPADDR, 32'd0);
        drop_reqs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.ACK0 || bus.ACK1) acks++;
        end
        check("no_ack_after_reset", 32'(acks), 32'd0);
        do_txn(vecs[0]);

        repeat (2) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
